// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync,
// validates line/frame timing and reports lock, frame and error status.
module vga_sync_monitor #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Hsync,
    input  logic       i_Vsync,
    output logic [9:0] o_Pixel_X,
    output logic [9:0] o_Pixel_Y,
    output logic       o_Display_Area,
    output logic       o_Locked,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count,
    output logic [7:0] o_Error_Count,
    output logic       o_Timing_Error
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(TIMEOUT + 1);
    localparam int unsigned VW      = $clog2(V_TOTAL) + 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            hs_q, vs_q, hs_d, vs_d;
    logic [HW-1:0]   h_cnt_q, h_cur;
    logic [VW-1:0]   v_cnt_q, v_cur;
    logic            v_low_bad_q, v_low_bad_d;
    logic            frame_err_q, frame_err_d;

    logic            h_fall, h_rise, v_fall, v_rise;
    logic            line_err, hw_err, tmo_err, vedge_err, frame_err, err_now;
    logic            active;
    logic [9:0]      px_d, py_d;
    logic            da_d, locked_d, fs_d, te_d;
    logic [7:0]      fc_d, ec_d;

    // Edge detection and position recovery on the registered sync copies
    always_comb begin
        h_fall = hs_d & ~hs_q;
        h_rise = ~hs_d & hs_q;
        v_fall = vs_d & ~vs_q;
        v_rise = ~vs_d & vs_q;

        h_cur = h_cnt_q;
        if (h_fall)
            h_cur = '0;
        else if (h_cnt_q != HW'(TIMEOUT))
            h_cur = h_cnt_q + HW'(1);

        v_cur = v_cnt_q;
        if (h_fall) begin
            if (v_fall)
                v_cur = '0;
            else if (v_cnt_q != '1)
                v_cur = v_cnt_q + VW'(1);
        end

        line_err  = h_fall & (h_cnt_q != HW'(H_TOTAL - 1));
        hw_err    = h_rise & (h_cnt_q != HW'(H_SYNC - 1));
        tmo_err   = ~h_fall & (h_cnt_q == HW'(TIMEOUT - 1));
        vedge_err = (v_fall | v_rise) & ~h_fall;
        frame_err = v_fall & ((v_cnt_q != VW'(V_TOTAL - 1)) | v_low_bad_q);
        err_now   = line_err | hw_err | tmo_err | vedge_err | frame_err;

        // Vsync low width is captured at its rise and judged at the next fall
        v_low_bad_d = v_low_bad_q;
        if (v_rise)
            v_low_bad_d = ~h_fall | (v_cnt_q != VW'(V_SYNC - 1));

        active = (h_cur >= HW'(H_START)) && (h_cur < HW'(H_START + H_ACTIVE)) &&
                 (v_cur >= VW'(V_START)) && (v_cur < VW'(V_START + V_ACTIVE));
    end

    // Lock state machine and status counters
    always_comb begin
        state_d     = state_q;
        frame_err_d = frame_err_q;
        fc_d        = o_Frame_Count;
        ec_d        = o_Error_Count;
        te_d        = o_Timing_Error;
        fs_d        = 1'b0;

        case (state_q)
            SEARCH: begin
                if (v_fall) begin
                    state_d     = MEASURE;
                    frame_err_d = 1'b0;
                end
            end
            MEASURE: begin
                if (v_fall) begin
                    frame_err_d = 1'b0;
                    if (!(frame_err_q || err_now)) begin
                        state_d = LOCKED;
                        fc_d    = 8'd1;
                        fs_d    = 1'b1;
                    end
                end else begin
                    frame_err_d = frame_err_q | err_now;
                end
            end
            LOCKED: begin
                if (err_now) begin
                    state_d = SEARCH;
                    te_d    = 1'b1;
                    if (o_Error_Count != 8'hFF)
                        ec_d = o_Error_Count + 8'd1;
                end else if (v_fall) begin
                    fs_d = 1'b1;
                    fc_d = o_Frame_Count + 8'd1;
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
        da_d     = active & locked_d;
        px_d     = active ? 10'(h_cur - HW'(H_START)) : 10'd0;
        py_d     = active ? 10'(v_cur - VW'(V_START)) : 10'd0;
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q        <= SEARCH;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            hs_d           <= 1'b1;
            vs_d           <= 1'b1;
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            v_low_bad_q    <= 1'b0;
            frame_err_q    <= 1'b0;
            o_Pixel_X      <= '0;
            o_Pixel_Y      <= '0;
            o_Display_Area <= 1'b0;
            o_Locked       <= 1'b0;
            o_Frame_Start  <= 1'b0;
            o_Frame_Count  <= '0;
            o_Error_Count  <= '0;
            o_Timing_Error <= 1'b0;
        end else begin
            state_q        <= state_d;
            hs_q           <= i_Hsync;
            vs_q           <= i_Vsync;
            hs_d           <= hs_q;
            vs_d           <= vs_q;
            h_cnt_q        <= h_cur;
            v_cnt_q        <= v_cur;
            v_low_bad_q    <= v_low_bad_d;
            frame_err_q    <= frame_err_d;
            o_Pixel_X      <= px_d;
            o_Pixel_Y      <= py_d;
            o_Display_Area <= da_d;
            o_Locked       <= locked_d;
            o_Frame_Start  <= fs_d;
            o_Frame_Count  <= fc_d;
            o_Error_Count  <= ec_d;
            o_Timing_Error <= te_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a shrunken raster so full frames stay short.
module tb_vga_sync_monitor;

    localparam int H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
    localparam int V_ACTIVE = 3, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int TIMEOUT  = 20;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs  = 1'b1;
    logic       vs  = 1'b1;
    logic [9:0] px, py;
    logic       da, lk, fs, te;
    logic [7:0] fc, ec;

    int checks = 0;
    int errors = 0;
    int gh = 0, gv = 0, cur_len = H_TOTAL;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Hsync(hs), .i_Vsync(vs),
        .o_Pixel_X(px), .o_Pixel_Y(py), .o_Display_Area(da), .o_Locked(lk),
        .o_Frame_Start(fs), .o_Frame_Count(fc), .o_Error_Count(ec), .o_Timing_Error(te)
    );

    // Drive the raster pixel at (gh,gv) then advance the generator
    task automatic step();
        @(negedge clk);
        hs = (gh >= H_SYNC);
        vs = (gv >= V_SYNC);
        if (gh == cur_len - 1) begin
            gh      = 0;
            cur_len = H_TOTAL;
            gv      = (gv == V_TOTAL - 1) ? 0 : gv + 1;
        end else begin
            gh++;
        end
    endtask

    task automatic goto_pix(input int h, input int v);
        int guard = 0;
        while (!(gh == h && gv == v)) begin
            step();
            guard++;
            if (guard > 2 * H_TOTAL * V_TOTAL) begin
                $display("FAIL goto_pix never reached h=%0d v=%0d", h, v);
                $fatal(1);
            end
        end
        step();
    endtask

    // Outputs lag the driven pixel by two clocks
    task automatic lat2();
        step();
        step();
    endtask

    task automatic hold_step();
        @(negedge clk);
        hs = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({px, py, da, lk, fs, fc, ec, te} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs got px=%0d py=%0d da=%0b lk=%0b fs=%0b fc=%0d ec=%0d te=%0b exp all 0",
                     px, py, da, lk, fs, fc, ec, te);
        end
        rst = 1'b0;
        gh = 0; gv = 0; cur_len = H_TOTAL;
    endtask

    task automatic test_lock();
        for (int i = 0; i < H_TOTAL * V_TOTAL; i++) step();
        checks++;
        if ({lk, fc} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL lock_measure got lk=%0b fc=%0d exp lk=0 fc=0", lk, fc);
        end
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, fc, fs, ec, te} !== {1'b1, 8'd1, 1'b1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL lock_entry got lk=%0b fc=%0d fs=%0b ec=%0d te=%0b exp 1 1 1 0 0", lk, fc, fs, ec, te);
        end
        step();
        checks++;
        if ({fs, fc} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL frame_start_pulse got fs=%0b fc=%0d exp fs=0 fc=1", fs, fc);
        end
    endtask

    task automatic test_active();
        goto_pix(H_SYNC + H_BP, V_SYNC + V_BP);
        lat2();
        checks++;
        if ({px, py, da} !== {10'd0, 10'd0, 1'b1}) begin
            errors++;
            $display("FAIL first_pixel got x=%0d y=%0d da=%0b exp 0 0 1", px, py, da);
        end
        goto_pix(4, 4);
        lat2();
        checks++;
        if ({px, py, da} !== {10'd1, 10'd1, 1'b1}) begin
            errors++;
            $display("FAIL mid_pixel got x=%0d y=%0d da=%0b exp 1 1 1", px, py, da);
        end
        goto_pix(6, 5);
        lat2();
        checks++;
        if ({px, py, da} !== {10'd3, 10'd2, 1'b1}) begin
            errors++;
            $display("FAIL last_pixel got x=%0d y=%0d da=%0b exp 3 2 1", px, py, da);
        end
        step();
        checks++;
        if ({px, py, da} !== {10'd0, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL after_last got x=%0d y=%0d da=%0b exp 0 0 0", px, py, da);
        end
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, fc, fs} !== {1'b1, 8'd2, 1'b1}) begin
            errors++;
            $display("FAIL second_frame got lk=%0b fc=%0d fs=%0b exp 1 2 1", lk, fc, fs);
        end
    endtask

    task automatic test_short_line();
        goto_pix(0, 4);
        cur_len = H_TOTAL - 1;
        goto_pix(6, 4);
        lat2();
        checks++;
        if ({lk, ec, da, px, py} !== {1'b1, 8'd0, 1'b1, 10'd3, 10'd1}) begin
            errors++;
            $display("FAIL short_line_body got lk=%0b ec=%0d da=%0b x=%0d y=%0d exp 1 0 1 3 1", lk, ec, da, px, py);
        end
        step();
        checks++;
        if ({lk, da, ec, te} !== {1'b0, 1'b0, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL short_line_err got lk=%0b da=%0b ec=%0d te=%0b exp 0 0 1 1", lk, da, ec, te);
        end
        goto_pix(0, 0);
        lat2();
        checks++;
        if (lk !== 1'b0) begin
            errors++;
            $display("FAIL relock_early got lk=%0b exp 0", lk);
        end
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, ec, fc, te} !== {1'b1, 8'd1, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL relock got lk=%0b ec=%0d fc=%0d te=%0b exp 1 1 1 1", lk, ec, fc, te);
        end
    endtask

    task automatic test_timeout();
        goto_pix(H_SYNC, 4);
        repeat (TIMEOUT - 1 - H_SYNC) hold_step();
        repeat (2) hold_step();
        checks++;
        if ({lk, ec} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL timeout_early got lk=%0b ec=%0d exp 1 1", lk, ec);
        end
        hold_step();
        checks++;
        if ({lk, ec, te} !== {1'b0, 8'd2, 1'b1}) begin
            errors++;
            $display("FAIL timeout_hit got lk=%0b ec=%0d te=%0b exp 0 2 1", lk, ec, te);
        end
        repeat (20) hold_step();
        gh = 0; gv = 5; cur_len = H_TOTAL;
        goto_pix(0, 0);
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, ec} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL timeout_relock got lk=%0b ec=%0d exp 1 2", lk, ec);
        end
    endtask

    task automatic test_saturate();
        int exp_ec = 2;
        for (int it = 0; it < 300; it++) begin
            goto_pix(0, 1);
            cur_len = H_TOTAL - 1;
            goto_pix(0, 0);
            goto_pix(0, 0);
            lat2();
            exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
            checks++;
            if ({lk, ec} !== {1'b1, 8'(exp_ec)}) begin
                errors++;
                $display("FAIL saturate_iter%0d got lk=%0b ec=%0d exp lk=1 ec=%0d", it, lk, ec, exp_ec);
            end
        end
        checks++;
        if ({ec, te} !== {8'd255, 1'b1}) begin
            errors++;
            $display("FAIL saturate_final got ec=%0d te=%0b exp 255 1", ec, te);
        end
    endtask

    task automatic test_reset_mid();
        goto_pix(3, 4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({px, py, da, lk, fs, fc, ec, te} !== 40'd0) begin
            errors++;
            $display("FAIL async_reset got px=%0d py=%0d da=%0b lk=%0b fs=%0b fc=%0d ec=%0d te=%0b exp all 0",
                     px, py, da, lk, fs, fc, ec, te);
        end
        repeat (3) step();
        rst = 1'b0;
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, fc} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_relock_early got lk=%0b fc=%0d exp 0 0", lk, fc);
        end
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, fc, ec, te} !== {1'b1, 8'd1, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_relock got lk=%0b fc=%0d ec=%0d te=%0b exp 1 1 0 0", lk, fc, ec, te);
        end
        for (int k = 1; k <= 254; k++) begin
            goto_pix(0, 0);
            lat2();
        end
        checks++;
        if (fc !== 8'd255) begin
            errors++;
            $display("FAIL frame_count_255 got %0d exp 255", fc);
        end
        goto_pix(0, 0);
        lat2();
        checks++;
        if ({lk, fc, fs} !== {1'b1, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL frame_count_wrap got lk=%0b fc=%0d fs=%0b exp 1 0 1", lk, fc, fs);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_active();
        test_short_line();
        test_timeout();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
